// File: rtl/country_car_detector.sv
// Vehicle-loop conditioner: synchronises, debounces and holds the raw loop into X; flags stuck loops.
// Optional CAR_COUNT_EN macro adds a saturating 8-bit car_count output.
module country_car_detector #(
   parameter int unsigned DEB_CYCLES   = 4,
   parameter int unsigned HOLD_CYCLES  = 6,
   parameter int unsigned STUCK_CYCLES = 255
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       loop_raw,
   output logic       X,
   output logic       stuck
`ifdef CAR_COUNT_EN
   ,
   output logic [7:0] car_count
`endif
);

   localparam int unsigned CntMax = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned StW    = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StDebOn   = 3'd1,
      StPresent = 3'd2,
      StHold    = 3'd3,
      StStuck   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [StW-1:0]  st_cnt_q, st_cnt_d;
   logic            sync1_q, loop_s;
   logic            x_q, stuck_q;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         sync1_q  <= 1'b0;
         loop_s   <= 1'b0;
         state_q  <= StIdle;
         cnt_q    <= '0;
         st_cnt_q <= '0;
         x_q      <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         sync1_q  <= loop_raw;
         loop_s   <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         st_cnt_q <= st_cnt_d;
         // Outputs are flopped from the next state so they change on the same edge as the FSM.
         x_q      <= (state_d == StPresent) || (state_d == StHold);
         stuck_q  <= (state_d == StStuck);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      st_cnt_d = st_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (loop_s) begin
               state_d = StDebOn;
               cnt_d   = CntW'(1);
            end
         end
         StDebOn: begin
            if (!loop_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
               state_d  = StPresent;
               cnt_d    = '0;
               st_cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StPresent: begin
            if (!loop_s) begin
               state_d = StHold;
               cnt_d   = CntW'(1);
            end else if (st_cnt_q == StW'(STUCK_CYCLES - 1)) begin
               state_d = StStuck;
               cnt_d   = '0;
            end else begin
               st_cnt_d = st_cnt_q + StW'(1);
            end
         end
         StHold: begin
            if (loop_s) begin
               state_d  = StPresent;
               cnt_d    = '0;
               st_cnt_d = '0;
            end else if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStuck: begin
            // Leave only after a clean debounce-length run of low samples.
            if (loop_s) begin
               cnt_d = '0;
            end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d  = StIdle;
            cnt_d    = '0;
            st_cnt_d = '0;
         end
      endcase
   end

   assign X     = x_q;
   assign stuck = stuck_q;

`ifdef CAR_COUNT_EN
   logic [7:0] car_cnt_q;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         car_cnt_q <= '0;
      end else if ((state_q == StDebOn) && (state_d == StPresent) && (car_cnt_q != 8'hFF)) begin
         car_cnt_q <= car_cnt_q + 8'd1;
      end
   end

   assign car_count = car_cnt_q;
`endif

endmodule
